// File: rtl/layer_sched.sv
// layer_sched -- sequences the shared MAC/activation datapath through every
// neuron of every layer of a fully connected network.
//
// Per neuron: clear accumulator, stream weight/activation addresses with a
// valid/ready handshake, wait out the MAC pipeline, strobe the activation,
// then request a write-back into activation memory.
//
// Optional feature macro: LAYER_SCHED_ARGMAX_EN
//   defined   -> running signed max over output-layer write-backs, winning
//                index presented on pred from the DONE cycle onward.
//   undefined -> pred is tied to 0 and wb_data is ignored.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   start     in   begin inference (sampled only in IDLE)
//   mac_rdy   in   datapath accepts the current feed beat
//   wb_ack    in   activation RAM accepted the write-back
//   wb_data   in   activated result of the current write-back (argmax only)
//   busy      out  inference in progress
//   w_addr    out  flat weight ROM address
//   x_addr    out  activation RAM read address
//   mac_vld   out  feed beat valid
//   mac_last  out  current beat is the neuron's last input
//   mac_clr   out  one-cycle accumulator clear
//   act_en    out  one-cycle activation strobe
//   wb_en     out  write-back request
//   wb_addr   out  write-back address
//   layer     out  current layer index
//   done      out  one-cycle completion pulse
//   pred      out  argmax of the output layer
module layer_sched #(
  parameter int NO_HL   = 2,
  parameter int NO_NIL  = 784,
  parameter int NO_NHL  = 28,
  parameter int NO_NOL  = 10,
  parameter int MAC_LAT = 2,
  parameter int W_AW    = 15,
  parameter int X_AW    = 11,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mac_rdy,
  input  logic              wb_ack,
  input  logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic [W_AW-1:0]   w_addr,
  output logic [X_AW-1:0]   x_addr,
  output logic              mac_vld,
  output logic              mac_last,
  output logic              mac_clr,
  output logic              act_en,
  output logic              wb_en,
  output logic [X_AW-1:0]   wb_addr,
  output logic [1:0]        layer,
  output logic              done,
  output logic [3:0]        pred
);

  localparam int MAXN_IN  = (NO_NIL > NO_NHL) ? NO_NIL : NO_NHL;
  localparam int MAXN_OUT = (NO_NHL > NO_NOL) ? NO_NHL : NO_NOL;
  // Input counter must hold N_IN itself (it steps past the last beat).
  localparam int IW = $clog2(MAXN_IN + 1);
  localparam int NW = $clog2(MAXN_OUT + 1);
  localparam int DW = $clog2(MAC_LAT + 1);
  localparam logic [1:0] L_OUT = 2'(NO_HL);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_ACT   = 3'd4,
    S_WB    = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_i;
  logic [NW-1:0]   r_neuron;
  logic [1:0]      r_layer;
  logic [W_AW-1:0] r_w_addr;
  logic [DW-1:0]   r_drain;

  logic [IW-1:0]   w_in_last;
  logic [NW-1:0]   w_out_last;
  logic            w_feed_last;
  logic            w_neuron_last;
  logic            w_layer_last;
  logic            w_drain_end;
  logic [X_AW-1:0] w_rd_base;
  logic [X_AW-1:0] w_wr_base;

  // Layer geometry and memory map, all derived from registered counters.
  assign w_in_last     = (r_layer == 2'd0) ? IW'(NO_NIL - 1) : IW'(NO_NHL - 1);
  assign w_out_last    = (r_layer == L_OUT) ? NW'(NO_NOL - 1) : NW'(NO_NHL - 1);
  assign w_feed_last   = (r_i == w_in_last);
  assign w_neuron_last = (r_neuron == w_out_last);
  assign w_layer_last  = (r_layer == L_OUT);
  assign w_drain_end   = (r_drain == DW'(MAC_LAT - 1));
  // Layer 0 reads the image at 0; layer k reads what layer k-1 wrote.
  assign w_rd_base = (r_layer == 2'd0) ? X_AW'(0)
                   : X_AW'(NO_NIL) + X_AW'(NO_NHL) * (X_AW'(r_layer) - X_AW'(1));
  assign w_wr_base = X_AW'(NO_NIL) + X_AW'(NO_NHL) * X_AW'(r_layer);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and output decode from registered state.
  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    mac_vld  = 1'b0;
    mac_last = 1'b0;
    mac_clr  = 1'b0;
    act_en   = 1'b0;
    wb_en    = 1'b0;
    done     = 1'b0;
    x_addr   = X_AW'(0);
    wb_addr  = X_AW'(0);
    case (r_state)
      S_IDLE: begin
        w_next = start ? S_CLR : S_IDLE;
      end
      S_CLR: begin
        busy    = 1'b1;
        mac_clr = 1'b1;
        w_next  = S_FEED;
      end
      S_FEED: begin
        busy     = 1'b1;
        mac_vld  = 1'b1;
        mac_last = w_feed_last;
        x_addr   = w_rd_base + X_AW'(r_i);
        w_next   = (mac_rdy && w_feed_last) ? S_DRAIN : S_FEED;
      end
      S_DRAIN: begin
        busy   = 1'b1;
        w_next = w_drain_end ? S_ACT : S_DRAIN;
      end
      S_ACT: begin
        busy   = 1'b1;
        act_en = 1'b1;
        w_next = S_WB;
      end
      S_WB: begin
        busy    = 1'b1;
        wb_en   = 1'b1;
        wb_addr = w_wr_base + X_AW'(r_neuron);
        if (wb_ack) begin
          w_next = (w_neuron_last && w_layer_last) ? S_DONE : S_CLR;
        end else begin
          w_next = S_WB;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Sequencing counters: input index, neuron, layer, flat weight address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i      <= '0;
      r_neuron <= '0;
      r_layer  <= 2'd0;
      r_w_addr <= '0;
      r_drain  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_layer  <= 2'd0;
            r_neuron <= '0;
            r_w_addr <= '0;
          end
        end
        S_CLR: begin
          r_i     <= '0;
          r_drain <= '0;
        end
        S_FEED: begin
          if (mac_rdy) begin
            r_i      <= r_i + IW'(1);
            r_w_addr <= r_w_addr + W_AW'(1);
          end
        end
        S_DRAIN: begin
          r_drain <= r_drain + DW'(1);
        end
        S_WB: begin
          if (wb_ack) begin
            if (!w_neuron_last) begin
              r_neuron <= r_neuron + NW'(1);
            end else if (!w_layer_last) begin
              r_layer  <= r_layer + 2'd1;
              r_neuron <= '0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign w_addr = r_w_addr;
  assign layer  = r_layer;

`ifdef LAYER_SCHED_ARGMAX_EN
  logic signed [DATA_W-1:0] r_max;
  logic [3:0]               r_arg;
  logic [3:0]               r_pred;
  logic                     w_out_ack;
  logic                     w_take;

  assign w_out_ack = (r_state == S_WB) && wb_ack && w_layer_last;
  // Neuron 0 always seeds; later neurons win only on strictly greater.
  assign w_take    = (r_neuron == '0) || ($signed(wb_data) > r_max);

  // Running max over output-layer write-backs; pred loads as DONE is entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_max  <= '0;
      r_arg  <= 4'd0;
      r_pred <= 4'd0;
    end else if (w_out_ack) begin
      if (w_take) begin
        r_max <= $signed(wb_data);
        r_arg <= 4'(r_neuron);
      end
      if (w_neuron_last) begin
        r_pred <= w_take ? 4'(r_neuron) : r_arg;
      end
    end
  end

  assign pred = r_pred;
`else
  logic w_unused_wb_data;
  assign w_unused_wb_data = ^wb_data;
  assign pred = 4'd0;
`endif

endmodule
